// File: rtl/branch_ctrl.sv
// branch_ctrl: decode-stage branch sequencing controller.
// Resolves a branch when its operands are available and drives PC_sel to
// the fetch mux. It stalls PC and IF/ID while operands are still in flight
// (bounded by MAX_WAIT) and flushes wrong-path fetches for FLUSH_CYCLES
// after a taken branch.
// Optional feature macro BRANCH_STATS_EN: saturating resolved/taken branch
// counters on br_total/br_taken. When the macro is undefined, both ports are tied to 0.
module branch_ctrl #(
    parameter int FLUSH_CYCLES = 1,   // legal 1..7
    parameter int MAX_WAIT     = 3,   // legal 1..15
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             de_valid,
    input  logic [1:0]       DE_control,
    input  logic             cmp,
    input  logic             opnd_ready,
    output logic             PC_sel,
    output logic             pc_stall,
    output logic             if_flush,
    output logic             wait_timeout,
    output logic [CNT_W-1:0] br_total,
    output logic [CNT_W-1:0] br_taken
);

    typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [3:0] WAIT_MAX   = 4'(MAX_WAIT);

    state_t     state, state_nxt;
    logic [2:0] flush_cnt, flush_cnt_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;
    logic       timeout_set;
    logic       br;
    logic       taken;

    assign br    = de_valid & DE_control[1];
    assign taken = DE_control[0] ~^ cmp;

    // State and counter registers; async reset discards any pending wait or flush.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            flush_cnt    <= 3'd0;
            wait_cnt     <= 4'd0;
            wait_timeout <= 1'b0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            wait_cnt  <= wait_cnt_nxt;
            if (timeout_set)
                wait_timeout <= 1'b1;
        end
    end

    // Next-state and combinational outputs; reset forces all outputs low.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        wait_cnt_nxt  = wait_cnt;
        timeout_set   = 1'b0;
        PC_sel        = 1'b0;
        pc_stall      = 1'b0;
        if_flush      = 1'b0;

        case (state)
            IDLE, WAIT: begin
                if (!br) begin
                    state_nxt    = IDLE;
                    wait_cnt_nxt = 4'd0;
                end else if (opnd_ready) begin
                    // Resolve: zero latency from operand arrival.
                    PC_sel       = taken;
                    wait_cnt_nxt = 4'd0;
                    state_nxt    = IDLE;
                    if (taken) begin
                        if_flush = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_nxt     = FLUSH;
                            flush_cnt_nxt = FLUSH_INIT;
                        end
                    end
                end else if (state == IDLE) begin
                    pc_stall     = 1'b1;
                    state_nxt    = WAIT;
                    wait_cnt_nxt = 4'd1;
                end else if (wait_cnt < WAIT_MAX) begin
                    pc_stall     = 1'b1;
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end else begin
                    // Give up waiting: release the stall and treat the branch as not taken.
                    timeout_set  = 1'b1;
                    state_nxt    = IDLE;
                    wait_cnt_nxt = 4'd0;
                end
            end
            FLUSH: begin
                // Decode holds a bubble here, so branch inputs are ignored.
                if_flush = 1'b1;
                if (flush_cnt <= 3'd1) begin
                    state_nxt     = IDLE;
                    flush_cnt_nxt = 3'd0;
                end else begin
                    flush_cnt_nxt = flush_cnt - 3'd1;
                end
            end
            default: begin
                state_nxt     = IDLE;
                flush_cnt_nxt = 3'd0;
                wait_cnt_nxt  = 4'd0;
            end
        endcase

        if (rst) begin
            PC_sel      = 1'b0;
            pc_stall    = 1'b0;
            if_flush    = 1'b0;
            timeout_set = 1'b0;
        end
    end

`ifdef BRANCH_STATS_EN
    logic resolve;

    assign resolve = br & opnd_ready & (state != FLUSH);

    // Saturating statistics counters for resolved and taken branches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_total <= '0;
            br_taken <= '0;
        end else if (resolve) begin
            if (br_total != {CNT_W{1'b1}})
                br_total <= br_total + 1'b1;
            if (taken && br_taken != {CNT_W{1'b1}})
                br_taken <= br_taken + 1'b1;
        end
    end
`else
    assign br_total = '0;
    assign br_taken = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: table-driven directed test of branch_ctrl, plus
// hand-written sequences for the multi-cycle flush and reset-mid-flush cases.
module tb_branch_ctrl;

    logic        clk;
    logic        rst;
    logic        de_valid;
    logic [1:0]  DE_control;
    logic        cmp;
    logic        opnd_ready;

    logic        pc_sel_a, stall_a, flush_a, to_a;
    logic [15:0] tot_a, tkn_a;
    logic        pc_sel_b, stall_b, flush_b, to_b;
    logic [15:0] tot_b, tkn_b;

    int checks = 0;
    int errors = 0;

`ifdef BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // Default instance: FLUSH_CYCLES=1, MAX_WAIT=3.
    branch_ctrl dut (
        .clk(clk), .rst(rst), .de_valid(de_valid), .DE_control(DE_control),
        .cmp(cmp), .opnd_ready(opnd_ready), .PC_sel(pc_sel_a),
        .pc_stall(stall_a), .if_flush(flush_a), .wait_timeout(to_a),
        .br_total(tot_a), .br_taken(tkn_a)
    );

    // Multi-cycle flush instance: FLUSH_CYCLES=3.
    branch_ctrl #(.FLUSH_CYCLES(3)) dut_f3 (
        .clk(clk), .rst(rst), .de_valid(de_valid), .DE_control(DE_control),
        .cmp(cmp), .opnd_ready(opnd_ready), .PC_sel(pc_sel_b),
        .pc_stall(stall_b), .if_flush(flush_b), .wait_timeout(to_b),
        .br_total(tot_b), .br_taken(tkn_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        dv;
        logic [1:0]  ctrl;
        logic        cmp;
        logic        rdy;
        logic        e_sel;
        logic        e_stall;
        logic        e_flush;
        logic        e_to;
        logic [15:0] e_tot;
        logic [15:0] e_tkn;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(logic r, logic dv, logic [1:0] c, logic cm, logic rd,
                                logic s, logic st, logic f, logic t,
                                logic [15:0] tot, logic [15:0] tkn);
        vec_t v;
        v.rst = r; v.dv = dv; v.ctrl = c; v.cmp = cm; v.rdy = rd;
        v.e_sel = s; v.e_stall = st; v.e_flush = f; v.e_to = t;
        v.e_tot = tot; v.e_tkn = tkn;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic dv, input logic [1:0] c,
                         input logic cm, input logic rd);
        rst = r; de_valid = dv; DE_control = c; cmp = cm; opnd_ready = rd;
    endtask

    initial begin
        drive(1'b1, 1'b1, 2'b11, 1'b1, 1'b1);

        //                 rst dv ctrl  cmp rdy  sel stl fls to  tot tkn
        vecs[0]  = mk(1, 1, 2'b11, 1, 1,  0, 0, 0, 0,  0, 0); // held in reset
        vecs[1]  = mk(0, 1, 2'b11, 1, 1,  1, 0, 1, 0,  0, 0); // release: beq taken
        vecs[2]  = mk(0, 0, 2'b11, 1, 1,  0, 0, 0, 0,  1, 1); // single flush over
        vecs[3]  = mk(0, 1, 2'b10, 1, 1,  0, 0, 0, 0,  1, 1); // bne not taken
        vecs[4]  = mk(0, 1, 2'b10, 0, 1,  1, 0, 1, 0,  2, 1); // bne taken
        vecs[5]  = mk(0, 1, 2'b11, 0, 1,  0, 0, 0, 0,  3, 2); // beq not taken
        vecs[6]  = mk(0, 1, 2'b01, 1, 1,  0, 0, 0, 0,  4, 2); // not a branch
        vecs[7]  = mk(0, 1, 2'b11, 1, 0,  0, 1, 0, 0,  4, 2); // wait 1
        vecs[8]  = mk(0, 1, 2'b11, 1, 0,  0, 1, 0, 0,  4, 2); // wait 2
        vecs[9]  = mk(0, 1, 2'b11, 1, 1,  1, 0, 1, 0,  4, 2); // operands arrive
        vecs[10] = mk(0, 0, 2'b00, 0, 0,  0, 0, 0, 0,  5, 3);
        vecs[11] = mk(0, 1, 2'b11, 1, 0,  0, 1, 0, 0,  5, 3); // timeout run
        vecs[12] = mk(0, 1, 2'b11, 1, 0,  0, 1, 0, 0,  5, 3);
        vecs[13] = mk(0, 1, 2'b11, 1, 0,  0, 1, 0, 0,  5, 3);
        vecs[14] = mk(0, 1, 2'b11, 1, 0,  0, 0, 0, 0,  5, 3); // timeout cycle
        vecs[15] = mk(0, 0, 2'b00, 0, 0,  0, 0, 0, 1,  5, 3); // sticky flag set
        vecs[16] = mk(0, 1, 2'b11, 1, 0,  0, 1, 0, 1,  5, 3); // enter wait
        vecs[17] = mk(0, 0, 2'b11, 1, 0,  0, 0, 0, 1,  5, 3); // br drops in wait
        vecs[18] = mk(0, 1, 2'b11, 1, 1,  1, 0, 1, 1,  5, 3); // back in idle
        vecs[19] = mk(1, 1, 2'b11, 1, 1,  0, 0, 0, 0,  0, 0); // reset clears sticky
        vecs[20] = mk(0, 0, 2'b00, 0, 0,  0, 0, 0, 0,  0, 0);
        vecs[21] = mk(0, 1, 2'b10, 0, 0,  0, 1, 0, 0,  0, 0); // enter wait
        vecs[22] = mk(1, 1, 2'b10, 0, 0,  0, 0, 0, 0,  0, 0); // reset mid-wait
        vecs[23] = mk(0, 0, 2'b00, 0, 0,  0, 0, 0, 0,  0, 0);

        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].rst, vecs[i].dv, vecs[i].ctrl, vecs[i].cmp, vecs[i].rdy);
            @(negedge clk);
            check($sformatf("v%0d PC_sel", i), {31'd0, pc_sel_a}, {31'd0, vecs[i].e_sel});
            check($sformatf("v%0d pc_stall", i), {31'd0, stall_a}, {31'd0, vecs[i].e_stall});
            check($sformatf("v%0d if_flush", i), {31'd0, flush_a}, {31'd0, vecs[i].e_flush});
            check($sformatf("v%0d wait_timeout", i), {31'd0, to_a}, {31'd0, vecs[i].e_to});
            check($sformatf("v%0d stats", i), {tot_a, tkn_a},
                  STATS ? {vecs[i].e_tot, vecs[i].e_tkn} : 32'd0);
        end

        // Multi-cycle flush on the FLUSH_CYCLES=3 instance.
        @(posedge clk); #1; drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        @(posedge clk); #1; drive(1'b0, 1'b1, 2'b11, 1'b1, 1'b1);
        @(negedge clk);
        check("f3 c1 PC_sel", {31'd0, pc_sel_b}, 32'd1);
        check("f3 c1 if_flush", {31'd0, flush_b}, 32'd1);
        @(posedge clk); #1;                       // branch still presented: ignored
        @(negedge clk);
        check("f3 c2 {sel,stall,flush}", {29'd0, pc_sel_b, stall_b, flush_b}, 32'b001);
        @(posedge clk); #1; opnd_ready = 1'b0;    // would stall if not ignored
        @(negedge clk);
        check("f3 c3 {sel,stall,flush}", {29'd0, pc_sel_b, stall_b, flush_b}, 32'b001);
        @(posedge clk); #1; de_valid = 1'b0;
        @(negedge clk);
        check("f3 c4 {sel,stall,flush}", {29'd0, pc_sel_b, stall_b, flush_b}, 32'b000);
        check("f3 stats", {tot_b, tkn_b}, STATS ? {16'd1, 16'd1} : 32'd0);

        // Reset in cycle 2 of a multi-cycle flush.
        @(posedge clk); #1; drive(1'b0, 1'b1, 2'b11, 1'b1, 1'b1);
        @(negedge clk);
        check("f3 r1 if_flush", {31'd0, flush_b}, 32'd1);
        @(posedge clk); #1; de_valid = 1'b0;
        @(negedge clk);
        check("f3 r2 if_flush", {31'd0, flush_b}, 32'd1);
        rst = 1'b1;
        #1;
        check("f3 rst if_flush", {31'd0, flush_b}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("f3 post-rst if_flush", {31'd0, flush_b}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("f3 post-rst2 if_flush", {31'd0, flush_b}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Sequencing controller for the decode-stage branch resolution path.
- Decides when the branch comparator result is valid and drives PC_sel to the fetch mux.
- Stalls PC and IF/ID while branch operands are still in flight, then squashes wrong-path fetches after a taken branch.
- Sits in instruction_decode, between hazard/forwarding logic and the fetch stage.

Parameters:
FLUSH_CYCLES, 1, cycles if_flush is asserted per taken branch (legal 1..7)
MAX_WAIT, 3, max consecutive operand-wait cycles before timeout (legal 1..15)
CNT_W, 16, width of statistics counters (only used with BRANCH_STATS_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
de_valid  in  1  decode stage holds a valid instruction
DE_control  in  2  [1]=instruction is a branch, [0]=sense (1: take when cmp=1 / beq, 0: take when cmp=0 / bne)
cmp  in  1  comparator equality result, meaningful only when opnd_ready=1
opnd_ready  in  1  both branch operands forwarded/available this cycle
PC_sel  out  1  1: fetch loads branch target this cycle
pc_stall  out  1  hold PC and IF/ID register
if_flush  out  1  clear IF/ID at next edge (insert bubble)
wait_timeout  out  1  sticky; set when an operand wait exceeds MAX_WAIT
br_total  out  CNT_W  resolved branches (0 without BRANCH_STATS_EN)
br_taken  out  CNT_W  taken branches (0 without BRANCH_STATS_EN)

Behaviour:
- States: IDLE, WAIT, FLUSH.
- Registers: state, 3-bit flush_cnt, 4-bit wait_cnt, wait_timeout.
- Outputs are combinational from state and inputs. All outputs are 0 while rst=1.
- Reset: async to IDLE. flush_cnt=0, wait_cnt=0, wait_timeout=0, counters=0.
- Definitions:
  - br = de_valid & DE_control[1]
  - taken = (DE_control[0] ~^ cmp)
  - resolve = opnd_ready in IDLE or WAIT with br=1
- IDLE, br=0: all outputs 0; stay in IDLE.
- IDLE, br=1, opnd_ready=1:
  - PC_sel=taken, pc_stall=0, same cycle (zero latency).
  - If taken: if_flush=1 this cycle. If FLUSH_CYCLES>1, go to FLUSH with flush_cnt=FLUSH_CYCLES-1; else stay in IDLE.
  - If not taken: stay in IDLE.
- IDLE, br=1, opnd_ready=0: pc_stall=1, PC_sel=0; go to WAIT with wait_cnt=1.
- WAIT: DE_control and cmp are sampled live (decode is held).
  - opnd_ready=0 and wait_cnt<MAX_WAIT: pc_stall=1; wait_cnt++.
  - opnd_ready=0 and wait_cnt=MAX_WAIT: pc_stall=0, PC_sel=0 (branch treated not-taken); set wait_timeout; go to IDLE.
  - opnd_ready=1: resolve exactly as in IDLE; wait_cnt cleared.
  - br drops to 0: go to IDLE, outputs 0.
- FLUSH: if_flush=1, PC_sel=0, pc_stall=0; de_valid/DE_control ignored (decode holds a bubble). Decrement flush_cnt; go to IDLE when flush_cnt reaches 1 at the clock edge.
- PC_sel and pc_stall are never both 1.
- wait_timeout clears only on rst.
- Reset mid-WAIT or mid-FLUSH: outputs drop to 0 immediately; no pending flush survives reset.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: br_total increments on every resolve cycle (timeouts excluded); br_taken increments on resolve cycles with taken=1. Both saturate at 2^CNT_W-1 and reset to 0.
- Undefined: no counter logic; br_total and br_taken are tied to 0; ports remain present.

Test Plan:
- Reset: rst=1 with de_valid=1, DE_control=2'b11, cmp=1 -> all outputs 0. Release rst -> PC_sel=1 the same cycle.
- beq taken, operands ready: DE_control=2'b11, cmp=1, opnd_ready=1, FLUSH_CYCLES=1 -> PC_sel=1, if_flush=1 for one cycle, next cycle all 0. With BRANCH_STATS_EN: br_total=1, br_taken=1.
- bne not taken: DE_control=2'b10, cmp=1, opnd_ready=1 -> PC_sel=0, if_flush=0, pc_stall=0. With BRANCH_STATS_EN: br_total=1, br_taken=0.
- Operand wait: DE_control=2'b11, cmp=1, opnd_ready=0 for 2 cycles then 1 -> pc_stall=1 for 2 cycles, then PC_sel=1 and if_flush=1; wait_timeout stays 0.
- Timeout: MAX_WAIT=3, opnd_ready held 0 -> pc_stall=1 for 3 cycles, then pc_stall=0, PC_sel=0, wait_timeout=1 (sticky until rst).
- Multi-cycle flush: FLUSH_CYCLES=3, taken branch -> if_flush=1 for exactly 3 cycles; a branch presented in cycles 2-3 is ignored. Assert rst in cycle 2 -> if_flush drops to 0 immediately.
